// File: rtl/inst_rom.sv
// Instruction ROM with a byte-stream program loader.
// A loader stream (16-bit big-endian word count, then big-endian 32-bit words)
// fills the memory; the core is held in reset until the load completes.
module inst_rom #(
  parameter int unsigned DEPTH_LOG2 = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ce_i,
  input  logic [31:0] addr_i,
  output logic [31:0] inst_o,
  input  logic        ld_start_i,
  input  logic        ld_valid_i,
  input  logic [7:0]  ld_byte_i,
  output logic        ld_ready_o,
  output logic        ld_done_o,
  output logic        ld_err_o,
  output logic        cpu_rst_o
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_HDR  = 3'd1,
    S_LOAD = 3'd2,
    S_RUN  = 3'd3,
    S_ERR  = 3'd4
  } state_t;

  state_t                state_q, state_d;
  logic [1:0]            cnt_q, cnt_d;
  logic [DEPTH_LOG2-1:0] ptr_q, ptr_d;
  logic [15:0]           hdr_q, hdr_d;
  logic [23:0]           shift_q, shift_d;
  logic                  we_c;
  logic [31:0]           wdata_c;
  logic                  xfer_c;
  logic [15:0]           n_c;
  logic                  unused_addr_c;

  logic [31:0] mem [DEPTH];

  // Status outputs decode straight from the state register.
  assign ld_ready_o = (state_q == S_HDR) || (state_q == S_LOAD);
  assign ld_done_o  = (state_q == S_RUN);
  assign ld_err_o   = (state_q == S_ERR);
  assign cpu_rst_o  = (state_q != S_RUN);

  assign xfer_c = ld_valid_i && ld_ready_o;
  assign n_c    = {hdr_q[15:8], ld_byte_i};

  // Zero-latency fetch port; byte offset and high address bits are dropped.
  assign inst_o = (state_q == S_RUN && ce_i) ? mem[addr_i[DEPTH_LOG2+1:2]] : 32'h0;
  assign unused_addr_c = ^{addr_i[31:DEPTH_LOG2+2], addr_i[1:0]};

  // Next-state and loader datapath.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    hdr_d   = hdr_q;
    shift_d = shift_q;
    we_c    = 1'b0;
    wdata_c = {shift_q, ld_byte_i};
    case (state_q)
      S_IDLE, S_RUN, S_ERR: begin
        if (ld_start_i) begin
          state_d = S_HDR;
          cnt_d   = 2'd0;
          ptr_d   = '0;
          hdr_d   = 16'h0;
          shift_d = 24'h0;
        end
      end
      S_HDR: begin
        if (xfer_c) begin
          if (cnt_q == 2'd0) begin
            hdr_d = {ld_byte_i, 8'h0};
            cnt_d = 2'd1;
          end else begin
            hdr_d = n_c;
            cnt_d = 2'd0;
            if (n_c == 16'h0)                state_d = S_RUN;
            else if (32'(n_c) > DEPTH)       state_d = S_ERR;
            else                             state_d = S_LOAD;
          end
        end
      end
      S_LOAD: begin
        if (xfer_c) begin
          if (cnt_q == 2'd3) begin
            we_c  = 1'b1;
            ptr_d = ptr_q + DEPTH_LOG2'(1);
            cnt_d = 2'd0;
            if (32'(ptr_q) == 32'(hdr_q) - 32'd1) state_d = S_RUN;
          end else begin
            shift_d = {shift_q[15:0], ld_byte_i};
            cnt_d   = cnt_q + 2'd1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and loader registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 2'd0;
      ptr_q   <= '0;
      hdr_q   <= 16'h0;
      shift_q <= 24'h0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      hdr_q   <= hdr_d;
      shift_q <= shift_d;
    end
  end

  // Memory write; contents survive reset.
  always_ff @(posedge clk) begin
    if (!rst && we_c) mem[ptr_q] <= wdata_c;
  end

endmodule
